write_back: RTL and testbench

//  Final (WB) stage of the 64-bit LEGv8-style pipeline, after the memory-access stage.
//  - Selects the register-file write data: memory load data or ALU result.
//  - Registers the destination register, the data and the write enable.
//  - Presents one clean write request per accepted instruction to the register file.
//  - Suppresses writes to the hard-wired zero register (XZR, X31).

---
 rtl/write_back.sv | 53 +++++
 tb/tb_write_back.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// Write-back stage: picks load data or ALU result and registers one register-file
// write request per cycle; writes aimed at the zero register are suppressed.
module write_back #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] wbReg,
    input  logic [DATA_W-1:0] loadedData,
    input  logic [DATA_W-1:0] Results,
    input  logic              MemToReg,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] Data2Write,
    output logic [REG_AW-1:0] Reg2Write,
    output logic              oldRegWrite
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    logic [DATA_W-1:0] data_d, data_q;
    logic [REG_AW-1:0] reg_d,  reg_q;
    logic              we_d,   we_q;

    always_comb begin
        data_d = Results;
        reg_d  = wbReg;
        we_d   = 1'b0;
        if (MemToReg)
            data_d = loadedData;
        // MemToReg only steers data; the enable depends on RegWrite and the index alone
        if (RegWrite && (wbReg != ZERO_IDX))
            we_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            reg_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            reg_q  <= reg_d;
            we_q   <= we_d;
        end
    end

    assign Data2Write  = data_q;
    assign Reg2Write   = reg_q;
    assign oldRegWrite = we_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios plus a randomized stream
// compared against a simple behavioural model of the write request.
module tb_write_back;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  wbReg = '0;
    logic [63:0] loadedData = '0;
    logic [63:0] Results = '0;
    logic        MemToReg = 1'b0;
    logic        RegWrite = 1'b0;
    logic [63:0] Data2Write;
    logic [4:0]  Reg2Write;
    logic        oldRegWrite;

    int tests = 0;
    int fails = 0;

    write_back dut (
        .clk(clk), .reset(reset), .wbReg(wbReg), .loadedData(loadedData),
        .Results(Results), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .Data2Write(Data2Write), .Reg2Write(Reg2Write), .oldRegWrite(oldRegWrite)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [63:0] ld, input logic [63:0] res);
        reset = rst; RegWrite = rw; MemToReg = m2r; wbReg = rd; loadedData = ld; Results = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h0, 64'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (Data2Write !== 64'h0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d] got d=%h r=%0d we=%b exp d=0 r=0 we=0",
                         i, Data2Write, Reg2Write, oldRegWrite);
            end
        end
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b1, 1'b0, 5'd5, 64'hDEAD, 64'h1234);
        tick();
        tests++;
        if (Data2Write !== 64'h1234 || Reg2Write !== 5'd5 || oldRegWrite !== 1'b1) begin
            fails++;
            $display("FAIL alu got d=%h r=%0d we=%b exp d=1234 r=5 we=1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
        tick();
        tests++;
        if (Data2Write !== 64'hFFFF_FFFF_FFFF_FFFF || Reg2Write !== 5'd9 || oldRegWrite !== 1'b1) begin
            fails++;
            $display("FAIL load got d=%h r=%0d we=%b exp d=ffffffffffffffff r=9 we=1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_no_write();
        drive(1'b0, 1'b0, 1'b0, 5'd7, 64'h0, 64'h40);
        tick();
        tests++;
        if (Data2Write !== 64'h40 || Reg2Write !== 5'd7 || oldRegWrite !== 1'b0) begin
            fails++;
            $display("FAIL no_write got d=%h r=%0d we=%b exp d=40 r=7 we=0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        // a load that does not write the register file stays disabled
        drive(1'b0, 1'b0, 1'b1, 5'd12, 64'h77, 64'h88);
        tick();
        tests++;
        if (Data2Write !== 64'h77 || Reg2Write !== 5'd12 || oldRegWrite !== 1'b0) begin
            fails++;
            $display("FAIL load_no_write got d=%h r=%0d we=%b exp d=77 r=12 we=0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_xzr();
        drive(1'b0, 1'b1, 1'b0, 5'd31, 64'h0, 64'hABCD);
        tick();
        tests++;
        if (Data2Write !== 64'hABCD || Reg2Write !== 5'd31 || oldRegWrite !== 1'b0) begin
            fails++;
            $display("FAIL xzr got d=%h r=%0d we=%b exp d=abcd r=31 we=0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        // register 30 is an ordinary register and must write
        drive(1'b0, 1'b1, 1'b1, 5'd30, 64'h3030, 64'h0);
        tick();
        tests++;
        if (Data2Write !== 64'h3030 || Reg2Write !== 5'd30 || oldRegWrite !== 1'b1) begin
            fails++;
            $display("FAIL x30 got d=%h r=%0d we=%b exp d=3030 r=30 we=1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_hold();
        logic [63:0] d0;
        logic [4:0]  r0;
        logic        w0;
        drive(1'b0, 1'b1, 1'b0, 5'd4, 64'h0, 64'h4444);
        tick();
        d0 = 64'h4444; r0 = 5'd4; w0 = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'd31, 64'h9999, 64'h1111);
        #2;
        tests++;
        if (Data2Write !== d0 || Reg2Write !== r0 || oldRegWrite !== w0) begin
            fails++;
            $display("FAIL hold got d=%h r=%0d we=%b exp d=%h r=%0d we=%b",
                     Data2Write, Reg2Write, oldRegWrite, d0, r0, w0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ed;
        logic [4:0]  er;
        logic        ew;
        for (int i = 0; i < 8; i++) begin
            logic rst;
            rst = (i == 4);
            if (i % 2 == 0) drive(rst, 1'b1, 1'b0, 5'd1, 64'hEE, 64'h11);
            else            drive(rst, 1'b1, 1'b1, 5'd2, 64'h22, 64'hFF);
            if (rst)             begin ed = 64'h0;  er = 5'd0; ew = 1'b0; end
            else if (i % 2 == 0) begin ed = 64'h11; er = 5'd1; ew = 1'b1; end
            else                 begin ed = 64'h22; er = 5'd2; ew = 1'b1; end
            tick();
            tests++;
            if (Data2Write !== ed || Reg2Write !== er || oldRegWrite !== ew) begin
                fails++;
                $display("FAIL b2b[%0d] got d=%h r=%0d we=%b exp d=%h r=%0d we=%b",
                         i, Data2Write, Reg2Write, oldRegWrite, ed, er, ew);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] ld, res, ed;
        logic [4:0]  rd, er;
        logic        rw, m2r, rst, ew;
        for (int i = 0; i < 300; i++) begin
            ld  = {$urandom, $urandom};
            res = {$urandom, $urandom};
            rd  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            m2r = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 15) == 0);
            drive(rst, rw, m2r, rd, ld, res);
            if (rst) begin
                ed = 64'h0; er = 5'd0; ew = 1'b0;
            end else begin
                ed = m2r ? ld : res;
                er = rd;
                ew = rw && (int'(rd) != 31);
            end
            tick();
            tests++;
            if (Data2Write !== ed || Reg2Write !== er || oldRegWrite !== ew) begin
                fails++;
                $display("FAIL random[%0d] got d=%h r=%0d we=%b exp d=%h r=%0d we=%b",
                         i, Data2Write, Reg2Write, oldRegWrite, ed, er, ew);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_no_write();
        test_xzr();
        test_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
